// File: rtl/microproc_pkg.sv
// Shared types for the microprocessor sequencer: opcode and state
// encodings, opcode field position, and the control-word bundle that
// the decoder hands to the top level.
package microproc_pkg;

  // Opcode occupies the top nibble of a 12-bit instruction word.
  localparam int OPC_MSB = 11;
  localparam int OPC_LSB = 8;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_LDB = 4'h2,
    OP_ADD = 4'h3,
    OP_ADC = 4'h4,
    OP_JMP = 4'h5,
    OP_JOV = 4'h6,
    OP_LDI = 4'h7,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  // Datapath strobes, one bit per control input of the datapath.
  typedef struct packed {
    logic we_a;
    logic ctrl_a;
    logic we_b;
    logic cin;
    logic we_pc;
    logic ctrl_pc;
    logic ctrl_addr;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // True for the two arithmetic opcodes, the only ones that touch carry.
  function automatic logic updates_carry(input logic [OPC_W-1:0] op);
    return (op == OP_ADD) || (op == OP_ADC);
  endfunction

endpackage

// File: rtl/microproc_decode.sv
// Combinational instruction decoder: (state, opcode, carry) ->
// datapath control word plus an undefined-opcode indication.
module microproc_decode
  import microproc_pkg::*;
(
  input  state_e           state,
  input  logic [OPC_W-1:0] opcode,
  input  logic             carry,
  output ctrl_t            ctrl,
  output logic             illegal
);

  // Strobe generation; everything defaults to idle and only the listed
  // strobes of the current state/opcode are raised.
  always_comb begin
    ctrl    = CTRL_IDLE;
    illegal = 1'b0;
    case (state)
      ST_FETCH: begin
        // Address from PC, PC advances past the instruction word.
        ctrl.we_pc = 1'b1;
      end
      ST_EXEC: begin
        case (opcode)
          OP_NOP: ;
          OP_LDA: begin
            ctrl.we_a  = 1'b1;
            ctrl.we_pc = 1'b1;
          end
          OP_LDB: begin
            ctrl.we_b  = 1'b1;
            ctrl.we_pc = 1'b1;
          end
          OP_ADD: begin
            ctrl.we_a   = 1'b1;
            ctrl.ctrl_a = 1'b1;
          end
          OP_ADC: begin
            ctrl.we_a   = 1'b1;
            ctrl.ctrl_a = 1'b1;
            ctrl.cin    = carry;
          end
          OP_JMP: begin
            ctrl.we_pc   = 1'b1;
            ctrl.ctrl_pc = 1'b1;
          end
          OP_JOV: begin
            // Taken: load the operand into PC. Not taken: step over it.
            ctrl.we_pc   = 1'b1;
            ctrl.ctrl_pc = carry;
          end
          OP_LDI: begin
            ctrl.ctrl_addr = 1'b1;
            ctrl.we_a      = 1'b1;
          end
          OP_HLT: ;
          default: illegal = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/microproc_ctrl.sv
// Sequencer for the 12-bit microprocessor datapath. Each instruction
// takes a FETCH cycle followed by an EXEC cycle; HLT parks the block in
// HALT until reset. Optional single-step mode, enabled by defining
// MICROPROC_CTRL_STEP_EN, adds a STEP input and a WAIT state after every
// non-HLT EXEC.
module microproc_ctrl
  import microproc_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
`ifdef MICROPROC_CTRL_STEP_EN
  input  logic              STEP,
`endif
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              OVF,
  output logic              WE_A,
  output logic              CTRL_A,
  output logic              WE_B,
  output logic              CIN,
  output logic              WE_PC,
  output logic              CTRL_PC,
  output logic              CTRL_ADDR,
  output logic              HALTED,
  output logic              ILLEGAL,
  output logic [CNT_W-1:0]  INSTR_CNT
);

`ifdef MICROPROC_CTRL_STEP_EN
  localparam state_e POST_EXEC = ST_WAIT;
`else
  localparam state_e POST_EXEC = ST_FETCH;
`endif

  state_e           state_q, state_d;
  logic [OPC_W-1:0] ir_q, ir_d;
  logic             c_q, c_d;
  logic             illegal_q, illegal_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  ctrl_t dec_ctrl;
  logic  dec_illegal;
  ctrl_t ctrl_out;

  // Only the opcode nibble is kept; the operand byte of the instruction
  // word carries no meaning for the sequencer.
  logic unused_data_bits;
  assign unused_data_bits = ^DATA_IN;

  microproc_decode u_decode (
    .state   (state_q),
    .opcode  (ir_q),
    .carry   (c_q),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  // Next-state, IR capture, carry, sticky illegal flag and retire counter.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    c_d       = c_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_FETCH: begin
        ir_d    = DATA_IN[OPC_MSB:OPC_LSB];
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dec_illegal) begin
          illegal_d = 1'b1;
        end
        if (updates_carry(ir_q)) begin
          c_d = OVF;
        end
        state_d = (ir_q == OP_HLT) ? ST_HALT : POST_EXEC;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      ST_WAIT: begin
`ifdef MICROPROC_CTRL_STEP_EN
        state_d = STEP ? ST_FETCH : ST_WAIT;
`else
        state_d = ST_FETCH;
`endif
      end
      default: state_d = ST_FETCH;
    endcase
    halted_d = (state_d == ST_HALT);
  end

  // State and status registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_FETCH;
      ir_q      <= '0;
      c_q       <= 1'b0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      c_q       <= c_d;
      illegal_q <= illegal_d;
      halted_q  <= halted_d;
      cnt_q     <= cnt_d;
    end
  end

  // Reset forces every output low immediately, which also suppresses the
  // side effects of an instruction interrupted by reset.
  assign ctrl_out  = RESET ? CTRL_IDLE : dec_ctrl;
  assign WE_A      = ctrl_out.we_a;
  assign CTRL_A    = ctrl_out.ctrl_a;
  assign WE_B      = ctrl_out.we_b;
  assign CIN       = ctrl_out.cin;
  assign WE_PC     = ctrl_out.we_pc;
  assign CTRL_PC   = ctrl_out.ctrl_pc;
  assign CTRL_ADDR = ctrl_out.ctrl_addr;
  assign HALTED    = halted_q & ~RESET;
  assign ILLEGAL   = illegal_q & ~RESET;
  assign INSTR_CNT = RESET ? '0 : cnt_q;

endmodule

// File: tb/tb_microproc_ctrl.sv
// Testbench for microproc_ctrl. A small datapath and program memory sit
// around the controller; an instruction-level model predicts PC/A/B and
// the status outputs. Honours MICROPROC_CTRL_STEP_EN (STEP held high
// outside the step-mode sequence).
module tb_microproc_ctrl;

`ifdef MICROPROC_CTRL_STEP_EN
  localparam int CPI = 3;
`else
  localparam int CPI = 2;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
`ifdef MICROPROC_CTRL_STEP_EN
  logic        STEP = 1'b1;
`endif
  logic [11:0] DATA_IN;
  logic        OVF;
  logic        WE_A, CTRL_A, WE_B, CIN, WE_PC, CTRL_PC, CTRL_ADDR;
  logic        HALTED, ILLEGAL;
  logic [15:0] INSTR_CNT;

  int n_chk = 0;
  int n_fail = 0;

  microproc_ctrl #(.DATA_W(12), .CNT_W(16)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
`ifdef MICROPROC_CTRL_STEP_EN
    .STEP      (STEP),
`endif
    .DATA_IN   (DATA_IN),
    .OVF       (OVF),
    .WE_A      (WE_A),
    .CTRL_A    (CTRL_A),
    .WE_B      (WE_B),
    .CIN       (CIN),
    .WE_PC     (WE_PC),
    .CTRL_PC   (CTRL_PC),
    .CTRL_ADDR (CTRL_ADDR),
    .HALTED    (HALTED),
    .ILLEGAL   (ILLEGAL),
    .INSTR_CNT (INSTR_CNT)
  );

  always #5 CLK = ~CLK;

  // Datapath stand-in: A, B, PC, asynchronous 256-word memory.
  logic [11:0] mem [256];
  logic [11:0] dp_a = 12'd0, dp_b = 12'd0, dp_pc = 12'd0;
  logic [11:0] dp_addr;
  logic [12:0] dp_sum;
  logic [6:0]  strb;

  assign dp_addr = CTRL_ADDR ? dp_b : dp_pc;
  assign DATA_IN = mem[dp_addr[7:0]];
  assign dp_sum  = {1'b0, dp_a} + {1'b0, dp_b} + {12'd0, CIN};
  assign OVF     = dp_sum[12];
  assign strb    = {WE_A, CTRL_A, WE_B, CIN, WE_PC, CTRL_PC, CTRL_ADDR};

  always @(posedge CLK) begin
    if (RESET) begin
      dp_a  <= 12'd0;
      dp_b  <= 12'd0;
      dp_pc <= 12'd0;
    end else begin
      if (WE_A)  dp_a  <= CTRL_A ? dp_sum[11:0] : DATA_IN;
      if (WE_B)  dp_b  <= DATA_IN;
      if (WE_PC) dp_pc <= CTRL_PC ? DATA_IN : dp_pc + 12'd1;
    end
  end

  // Instruction-level reference model.
  int m_pc, m_a, m_b, m_c, m_cnt;
  bit m_ill, m_halt;

  task automatic model_reset();
    m_pc = 0; m_a = 0; m_b = 0; m_c = 0; m_cnt = 0; m_ill = 0; m_halt = 0;
  endtask

  task automatic model_step();
    int w, op, s;
    w = int'(mem[m_pc % 256]);
    op = w / 256;
    m_pc = (m_pc + 1) % 4096;
    m_cnt = m_cnt + 1;
    case (op)
      0: ;
      1: begin m_a = int'(mem[m_pc % 256]); m_pc = (m_pc + 1) % 4096; end
      2: begin m_b = int'(mem[m_pc % 256]); m_pc = (m_pc + 1) % 4096; end
      3: begin s = m_a + m_b; m_c = s / 4096; m_a = s % 4096; end
      4: begin s = m_a + m_b + m_c; m_c = s / 4096; m_a = s % 4096; end
      5: m_pc = int'(mem[m_pc % 256]);
      6: m_pc = (m_c != 0) ? int'(mem[m_pc % 256]) : (m_pc + 1) % 4096;
      7: m_a = int'(mem[m_b % 256]);
      15: m_halt = 1;
      default: m_ill = 1;
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // Hold reset two cycles; outputs must read zero throughout.
  task automatic do_reset();
    @(posedge CLK); #1 RESET = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      chk("rst strobes", 32'(strb), 32'd0);
      chk("rst halted", 32'(HALTED), 32'd0);
      chk("rst illegal", 32'(ILLEGAL), 32'd0);
      chk("rst cnt", 32'(INSTR_CNT), 32'd0);
      @(posedge CLK);
    end
    #1 RESET = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 12'h000;
  endtask

  typedef struct {
    string       name;
    logic [11:0] prog [8];
    int          idx;
    logic [6:0]  exp;
    logic        ill;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input string nm,
                         input logic [11:0] w0, input logic [11:0] w1,
                         input logic [11:0] w2, input logic [11:0] w3,
                         input logic [11:0] w4, input logic [11:0] w5,
                         input logic [11:0] w6, input logic [11:0] w7,
                         input int idx, input logic [6:0] ex, input logic ill);
    vec_t v;
    v.name = nm;
    v.prog[0] = w0; v.prog[1] = w1; v.prog[2] = w2; v.prog[3] = w3;
    v.prog[4] = w4; v.prog[5] = w5; v.prog[6] = w6; v.prog[7] = w7;
    v.idx = idx; v.exp = ex; v.ill = ill;
    vecs.push_back(v);
  endtask

  function automatic logic [11:0] rand_word();
    int r;
    logic [3:0] op;
    r = $urandom_range(0, 99);
    if (r < 5)       op = 4'hF;
    else if (r < 10) op = 4'($urandom_range(8, 14));
    else             op = 4'($urandom_range(0, 7));
    return {op, 8'($urandom)};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Strobe order: WE_A CTRL_A WE_B CIN WE_PC CTRL_PC CTRL_ADDR
    add_vec("NOP", 12'h000, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 1'b0);
    add_vec("LDA", 12'h1AB, 12'h123, 0, 0, 0, 0, 0, 0, 0, 7'b1000100, 1'b0);
    add_vec("LDB", 12'h200, 12'h005, 0, 0, 0, 0, 0, 0, 0, 7'b0010100, 1'b0);
    add_vec("ADD", 12'h300, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1100000, 1'b0);
    add_vec("ADC c0", 12'h400, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1100000, 1'b0);
    add_vec("ADC c1", 12'h100, 12'hFFF, 12'h200, 12'h001, 12'h300, 12'h400, 0, 0,
            3, 7'b1101000, 1'b0);
    add_vec("JMP", 12'h500, 12'h010, 0, 0, 0, 0, 0, 0, 0, 7'b0000110, 1'b0);
    add_vec("JOV taken", 12'h100, 12'hFFF, 12'h200, 12'h001, 12'h300, 12'h600, 12'h040, 0,
            3, 7'b0000110, 1'b0);
    add_vec("JOV not taken", 12'h100, 12'h001, 12'h200, 12'h001, 12'h300, 12'h600, 12'h040, 0,
            3, 7'b0000100, 1'b0);
    add_vec("LDI", 12'h200, 12'h005, 12'h700, 0, 0, 0, 0, 0, 1, 7'b1000001, 1'b0);
    add_vec("ILL 9", 12'h900, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 1'b1);
    add_vec("ILL E", 12'hEAB, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 1'b1);
    add_vec("HLT", 12'hF00, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 1'b0);

    // Table-driven EXEC strobe checks.
    foreach (vecs[v]) begin
      clear_mem();
      for (int i = 0; i < 8; i++) mem[i] = vecs[v].prog[i];
      do_reset();
      for (int cyc = 0; cyc <= vecs[v].idx * CPI + 2; cyc++) begin
        @(negedge CLK);
        if (cyc == 0) chk({vecs[v].name, " fetch"}, 32'(strb), 32'b0000100);
        if (cyc == vecs[v].idx * CPI + 1) chk(vecs[v].name, 32'(strb), 32'(vecs[v].exp));
        if (cyc == vecs[v].idx * CPI + 2) chk({vecs[v].name, " illegal"}, 32'(ILLEGAL), 32'(vecs[v].ill));
      end
      $display("vector %s done", vecs[v].name);
    end

    // LDA then reset in the middle of the next instruction's EXEC.
    clear_mem();
    mem[0] = 12'h100; mem[1] = 12'h123; mem[2] = 12'h100; mem[3] = 12'h456;
    do_reset();
    repeat (CPI + 1) @(negedge CLK);
    chk("lda pc", 32'(dp_pc), 32'd2);
    chk("lda a", 32'(dp_a), 32'h123);
    chk("lda cnt", 32'(INSTR_CNT), 32'd1);
    @(posedge CLK); #1 RESET = 1'b1;
    @(negedge CLK);
    chk("midrst strobes", 32'(strb), 32'd0);
    chk("midrst cnt", 32'(INSTR_CNT), 32'd0);
    @(posedge CLK); #1 RESET = 1'b0;
    @(negedge CLK);
    chk("midrst fetch", 32'(strb), 32'b0000100);
    chk("midrst a kept", 32'(dp_a), 32'h000);
    @(negedge CLK);
    chk("midrst exec", 32'(strb), 32'b1000100);
    $display("sequence mid-reset done");

    // Illegal opcode, then HLT held for ten cycles, then reset.
    clear_mem();
    mem[0] = 12'h900; mem[1] = 12'hF00;
    do_reset();
    repeat (CPI + 1) @(negedge CLK);
    chk("ill flag", 32'(ILLEGAL), 32'd1);
    @(negedge CLK);
    chk("hlt exec strobes", 32'(strb), 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      chk("halt strobes", 32'(strb), 32'd0);
      chk("halt halted", 32'(HALTED), 32'd1);
      chk("halt cnt", 32'(INSTR_CNT), 32'd2);
    end
    do_reset();
    @(negedge CLK);
    chk("post halt halted", 32'(HALTED), 32'd0);
    chk("post halt illegal", 32'(ILLEGAL), 32'd0);
    chk("post halt fetch", 32'(strb), 32'b0000100);
    $display("sequence illegal-halt done");

`ifdef MICROPROC_CTRL_STEP_EN
    // Step mode: parked in WAIT until a one-cycle STEP pulse.
    clear_mem();
    mem[0] = 12'h100; mem[1] = 12'h123; mem[2] = 12'h200; mem[3] = 12'h005;
    STEP = 1'b0;
    do_reset();
    repeat (2) @(negedge CLK);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("wait strobes", 32'(strb), 32'd0);
      chk("wait cnt", 32'(INSTR_CNT), 32'd1);
    end
    @(posedge CLK); #1 STEP = 1'b1;
    @(posedge CLK); #1 STEP = 1'b0;
    @(negedge CLK);
    chk("step fetch", 32'(strb), 32'b0000100);
    @(negedge CLK);
    chk("step exec ldb", 32'(strb), 32'b0010100);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("wait2 strobes", 32'(strb), 32'd0);
      chk("wait2 cnt", 32'(INSTR_CNT), 32'd2);
    end
    chk("step b", 32'(dp_b), 32'h005);
    STEP = 1'b1;
    $display("sequence step done");
`endif

    // Random programs against the instruction-level model.
    for (int p = 0; p < 10; p++) begin
      for (int i = 0; i < 256; i++) mem[i] = rand_word();
      model_reset();
      do_reset();
      for (int i = 0; i < 40; i++) begin
        repeat ((i == 0) ? 1 : CPI) @(negedge CLK);
        chk("rand pc", 32'(dp_pc), 32'(m_pc));
        chk("rand a", 32'(dp_a), 32'(m_a));
        chk("rand b", 32'(dp_b), 32'(m_b));
        chk("rand cnt", 32'(INSTR_CNT), 32'(m_cnt));
        chk("rand illegal", 32'(ILLEGAL), 32'(m_ill));
        chk("rand halted", 32'(HALTED), 32'(m_halt));
        if (m_halt) begin
          chk("rand halt strobes", 32'(strb), 32'd0);
          break;
        end
        model_step();
      end
      $display("random program %0d: %0d instructions", p, m_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
